// File: rtl/puf_seq_pkg.sv
// Shared state codes, counter widths and drive-polarity helpers for the
// PUF challenge sequencer.
package puf_seq_pkg;

    localparam int TIE_CNT_W = 4;
    localparam int TMR_W     = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_PROG    = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_SAMPLE  = 3'd4;
    localparam logic [2:0] ST_RESTORE = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // Which cell of the pair receives the positive pulse.
    typedef enum logic {
        POL_B_HIGH = 1'b0,
        POL_A_HIGH = 1'b1
    } pol_e;

    // A set challenge bit drives cell A positive; restore pulses invert that.
    function automatic pol_e prog_pol(input logic chal_bit, input logic restore);
        return (chal_bit ^ restore) ? POL_A_HIGH : POL_B_HIGH;
    endfunction

endpackage

// File: rtl/puf_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a
// load of N-1 yields a phase of exactly N cycles.
module puf_pulse_timer
    import puf_seq_pkg::*;
#(
    parameter int CNT_W = TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Program/compare sequencer for a differential memristive PUF cell pair.
// Build option PUF_SEQ_RESTORE_EN adds an inverse-polarity pulse after each sample.
//
// state   | meaning
// IDLE    | waiting for a challenge, chal_ready high
// CLEAR   | cell_clear held to reset both cells
// PROG    | programming pulse for the current bit
// SETTLE  | drives off, cells settling
// SAMPLE  | one cycle; conductances compared on the closing edge
// RESTORE | inverse pulse undoing this bit's programming (option only)
// DONE    | response held until resp_ready
module puf_challenge_sequencer
    import puf_seq_pkg::*;
#(
    parameter int CHAL_BITS     = 8,
    parameter int VIN_WIDTH     = 16,
    parameter int G_WIDTH       = 16,
    parameter int VPROG         = 1280,
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CLEAR_CYCLES  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        chal_valid,
    output logic                        chal_ready,
    input  logic [CHAL_BITS-1:0]        chal,
    output logic                        cell_clear,
    output logic                        cell_vin_valid,
    output logic signed [VIN_WIDTH-1:0] cell_vin_a,
    output logic signed [VIN_WIDTH-1:0] cell_vin_b,
    input  logic signed [G_WIDTH-1:0]   cell_g_a,
    input  logic signed [G_WIDTH-1:0]   cell_g_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [CHAL_BITS-1:0]        resp,
    output logic [TIE_CNT_W-1:0]        tie_cnt,
    output logic                        busy
);

    localparam int IDX_W = (CHAL_BITS > 1) ? $clog2(CHAL_BITS) : 1;
    localparam logic [IDX_W-1:0]            LAST_IDX    = IDX_W'(CHAL_BITS - 1);
    localparam logic [TIE_CNT_W-1:0]        TIE_MAX     = {TIE_CNT_W{1'b1}};
    localparam logic [TMR_W-1:0]            CLEAR_LOAD  = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [TMR_W-1:0]            PULSE_LOAD  = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]            SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic signed [VIN_WIDTH-1:0] V_POS       = VIN_WIDTH'(VPROG);
    localparam logic signed [VIN_WIDTH-1:0] V_NEG       = VIN_WIDTH'(-VPROG);

    logic [2:0]                  state_q, state_d;
    logic [IDX_W-1:0]            bit_idx_q, bit_idx_d;
    logic [CHAL_BITS-1:0]        chal_q, chal_d;
    logic [CHAL_BITS-1:0]        resp_q, resp_d;
    logic [TIE_CNT_W-1:0]        tie_q, tie_d;
    logic                        chal_ready_q, chal_ready_d;
    logic                        clear_q, clear_d;
    logic                        vin_valid_q, vin_valid_d;
    logic signed [VIN_WIDTH-1:0] vin_a_q, vin_a_d;
    logic signed [VIN_WIDTH-1:0] vin_b_q, vin_b_d;
    logic                        resp_valid_q, resp_valid_d;
    logic                        busy_q, busy_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             advance;
    logic             g_gt;
    logic             g_eq;
    pol_e             pol;

    puf_pulse_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign g_gt = (cell_g_a > cell_g_b);
    assign g_eq = (cell_g_a == cell_g_b);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        chal_d    = chal_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (chal_valid && chal_ready_q) begin
                    chal_d    = chal;
                    resp_d    = '0;
                    tie_d     = '0;
                    bit_idx_d = '0;
                    state_d   = ST_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_val   = CLEAR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (tmr_done) begin
                    state_d  = ST_PROG;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LOAD;
                end
            end
            ST_PROG: begin
                if (tmr_done) begin
                    if (SETTLE_CYCLES > 0) begin
                        state_d  = ST_SETTLE;
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD;
                    end else begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // A tie reads as 0 and is only recorded in the tie counter.
                resp_d[bit_idx_q] = g_gt;
                if (g_eq && (tie_q != TIE_MAX)) begin
                    tie_d = tie_q + TIE_CNT_W'(1);
                end
`ifdef PUF_SEQ_RESTORE_EN
                state_d  = ST_RESTORE;
                tmr_load = 1'b1;
                tmr_val  = PULSE_LOAD;
`else
                advance = 1'b1;
`endif
            end
`ifdef PUF_SEQ_RESTORE_EN
            ST_RESTORE: begin
                if (tmr_done) begin
                    advance = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (bit_idx_q == LAST_IDX) begin
                state_d = ST_DONE;
            end else begin
                bit_idx_d = bit_idx_q + IDX_W'(1);
                state_d   = ST_PROG;
                tmr_load  = 1'b1;
                tmr_val   = PULSE_LOAD;
            end
        end
    end

    // Outputs decode the next state so they line up with the state register.
    always_comb begin
        chal_ready_d = (state_d == ST_IDLE);
        clear_d      = (state_d == ST_CLEAR);
        resp_valid_d = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        vin_valid_d  = (state_d == ST_PROG) || (state_d == ST_RESTORE);
        pol          = prog_pol(chal_d[bit_idx_d], state_d == ST_RESTORE);
        vin_a_d      = '0;
        vin_b_d      = '0;
        if (vin_valid_d) begin
            if (pol == POL_A_HIGH) begin
                vin_a_d = V_POS;
                vin_b_d = V_NEG;
            end else begin
                vin_a_d = V_NEG;
                vin_b_d = V_POS;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_idx_q    <= '0;
            chal_q       <= '0;
            resp_q       <= '0;
            tie_q        <= '0;
            chal_ready_q <= 1'b0;
            clear_q      <= 1'b0;
            vin_valid_q  <= 1'b0;
            vin_a_q      <= '0;
            vin_b_q      <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            chal_q       <= chal_d;
            resp_q       <= resp_d;
            tie_q        <= tie_d;
            chal_ready_q <= chal_ready_d;
            clear_q      <= clear_d;
            vin_valid_q  <= vin_valid_d;
            vin_a_q      <= vin_a_d;
            vin_b_q      <= vin_b_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign chal_ready     = chal_ready_q;
    assign cell_clear     = clear_q;
    assign cell_vin_valid = vin_valid_q;
    assign cell_vin_a     = vin_a_q;
    assign cell_vin_b     = vin_b_q;
    assign resp_valid     = resp_valid_q;
    assign resp           = resp_q;
    assign tie_cnt        = tie_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer; honours PUF_SEQ_RESTORE_EN
// when the same define is given to the bench and the design.
module tb_puf_challenge_sequencer;

    localparam int CB    = 8;
    localparam int VPROG = 1280;
    localparam int P     = 4;
    localparam int S     = 2;
    localparam int CLR   = 2;
`ifdef PUF_SEQ_RESTORE_EN
    localparam int RP = P;
`else
    localparam int RP = 0;
`endif
    localparam int COST   = P + S + 1 + RP;
    localparam int T_DONE = 1 + CLR + CB * COST;

    typedef struct packed {
        logic [7:0]       chal;
        logic [7:0][15:0] ga;
        logic [7:0][15:0] gb;
    } job_t;

    typedef struct packed {
        logic [7:0] resp;
        logic [3:0] tie;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               chal_valid;
    logic               chal_ready;
    logic [7:0]         chal;
    logic               cell_clear;
    logic               cell_vin_valid;
    logic signed [15:0] cell_vin_a;
    logic signed [15:0] cell_vin_b;
    logic signed [15:0] cell_g_a;
    logic signed [15:0] cell_g_b;
    logic               resp_valid;
    logic               resp_ready;
    logic [7:0]         resp;
    logic [3:0]         tie_cnt;
    logic               busy;

    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   rr_mode = 0;
    exp_t exp_q[$];
    job_t pend_q[$];
    job_t cur;
    bit   active = 0;
    bit   got = 0;
    int   acc_cyc = 0;
    logic [7:0] held_resp;

    puf_challenge_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .chal_valid     (chal_valid),
        .chal_ready     (chal_ready),
        .chal           (chal),
        .cell_clear     (cell_clear),
        .cell_vin_valid (cell_vin_valid),
        .cell_vin_a     (cell_vin_a),
        .cell_vin_b     (cell_vin_b),
        .cell_g_a       (cell_g_a),
        .cell_g_b       (cell_g_b),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp           (resp),
        .tie_cnt        (tie_cnt),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: bit i is 1 when A conducts strictly more than B; ties read 0.
    function automatic exp_t model(input job_t j);
        exp_t e;
        int   ties;
        ties   = 0;
        e.resp = '0;
        for (int i = 0; i < CB; i++) begin
            if ($signed(j.ga[i]) > $signed(j.gb[i])) e.resp[i] = 1'b1;
            else if (j.ga[i] == j.gb[i]) ties++;
        end
        e.tie = 4'((ties > 15) ? 15 : ties);
        return e;
    endfunction

    // Expected {clear, vin_valid, resp_valid, chal_ready, busy, vin_a, vin_b}
    // in cycle t after the accept edge (t = 1 is the first cycle).
    function automatic logic [36:0] exp_trace(input int t, input logic [7:0] c);
        logic               clr, vv, pol;
        logic signed [15:0] a, b, vp;
        int                 i, k;
        clr = 1'b0;
        vv  = 1'b0;
        pol = 1'b0;
        a   = '0;
        b   = '0;
        vp  = 16'(VPROG);
        if (t <= CLR) begin
            clr = 1'b1;
        end else begin
            i = (t - 1 - CLR) / COST;
            k = (t - 1 - CLR) % COST;
            if (k < P) begin
                vv  = 1'b1;
                pol = c[i];
            end else if (k >= P + S + 1) begin
                vv  = 1'b1;
                pol = ~c[i];
            end
            if (vv) begin
                a = pol ? vp : -vp;
                b = -a;
            end
        end
        return {clr, vv, 1'b0, 1'b0, 1'b1, a, b};
    endfunction

    // Monitor, stub cells and response scoreboard.
    always @(negedge clk) begin
        int   t, bi;
        exp_t e;
        if (rst) begin
            active = 0;
            got    = 0;
        end else begin
            if (active) begin
                t = cyc - acc_cyc + 1;
                if (t < T_DONE) begin
                    chk("trace", {cell_clear, cell_vin_valid, resp_valid, chal_ready, busy,
                                  cell_vin_a, cell_vin_b}, exp_trace(t, cur.chal));
                    if (t > CLR) begin
                        bi = (t - 1 - CLR) / COST;
                        cell_g_a = cur.ga[bi];
                        cell_g_b = cur.gb[bi];
                    end else begin
                        cell_g_a = 16'($urandom);
                        cell_g_b = 16'($urandom);
                    end
                end else if (t > T_DONE + 300) begin
                    checks++;
                    $display("FAIL resp_timeout: no response %0d cycles after accept", t);
                    active = 0;
                end
            end
            if (resp_valid) begin
                if (!got) begin
                    got       = 1;
                    held_resp = resp;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_resp: got resp %0h with none pending", resp);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp", resp, e.resp);
                        chk("tie_cnt", tie_cnt, e.tie);
                        chk("resp_latency", active ? (cyc - acc_cyc + 1) : -1, T_DONE);
                    end
                end else begin
                    chk("resp_stable", resp, held_resp);
                    chk("ready_in_done", chal_ready, 1'b0);
                end
            end else if (got) begin
                got    = 0;
                active = 0;
                chk("ready_after_done", {chal_ready, busy}, 2'b10);
            end
            if (chal_valid && chal_ready) begin
                if (pend_q.size() != 0) cur = pend_q.pop_front();
                acc_cyc = cyc + 1;
                active  = 1;
            end
        end
    end

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = 1'($urandom_range(0, 1));
                default: resp_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input job_t j);
        int n;
        exp_q.push_back(model(j));
        pend_q.push_back(j);
        chal       = j.chal;
        chal_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!chal_ready && n < 1000);
        if (!chal_ready) begin
            checks++;
            $display("FAIL accept_timeout: chal_ready %0b after %0d cycles", chal_ready, n);
        end
        @(posedge clk);
        #1;
        chal_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || active) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            $display("FAIL idle_timeout: %0d responses outstanding", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic job_t rand_job();
        job_t j;
        int   va, vb;
        j.chal = 8'($urandom);
        for (int i = 0; i < CB; i++) begin
            va = int'($urandom_range(0, 6)) - 3;
            vb = int'($urandom_range(0, 6)) - 3;
            j.ga[i] = 16'(va * 40);
            j.gb[i] = 16'(vb * 40);
        end
        return j;
    endfunction

    initial begin
        job_t j;
        int   n;
        rst        = 1'b1;
        chal_valid = 1'b0;
        chal       = '0;
        cell_g_a   = '0;
        cell_g_b   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {chal_ready, cell_clear, cell_vin_valid, resp_valid, busy,
                              tie_cnt, resp, cell_vin_a, cell_vin_b}, 64'd0);
        #2 rst = 1'b0;
        #1 chk("ready_before_edge", chal_ready, 1'b0);
        @(posedge clk);
        #1 chk("ready_after_release", {chal_ready, busy}, 2'b10);

        // Polarity and alternating response.
        j.chal = 8'h01;
        for (int i = 0; i < CB; i++) begin
            j.ga[i] = (i % 2 == 0) ? 16'sd200 : 16'sd100;
            j.gb[i] = (i % 2 == 0) ? 16'sd100 : 16'sd200;
        end
        send(j);
        wait_idle();

        // Every compare ties.
        j.chal = 8'h3C;
        for (int i = 0; i < CB; i++) begin
            j.ga[i] = 16'sd128;
            j.gb[i] = 16'sd128;
        end
        send(j);
        wait_idle();

        // Backpressure on the response.
        rr_mode = 2;
        send(rand_job());
        n = 0;
        while (!resp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        rr_mode = 0;
        wait_idle();

        // Reset during bit 3 programming.
        j = rand_job();
        j.chal = 8'h08;
        send(j);
        repeat (CLR + 3 * COST + 1) @(posedge clk);
        #2;
        chk("bit3_drive", {cell_vin_valid, cell_vin_a}, {1'b1, 16'sd1280});
        void'(exp_q.pop_back());
        rst = 1'b1;
        #1;
        chk("mid_reset_outputs", {chal_ready, cell_clear, cell_vin_valid, resp_valid, busy,
                                  tie_cnt, resp, cell_vin_a, cell_vin_b}, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("ready_before_edge2", chal_ready, 1'b0);
        @(posedge clk);
        #1 chk("ready_after_release2", {chal_ready, busy}, 2'b10);

        j = rand_job();
        j.chal = 8'hA5;
        send(j);
        wait_idle();

        // Back-to-back random challenges with random response backpressure.
        rr_mode = 1;
        for (int k = 0; k < 8; k++) send(rand_job());
        wait_idle();
        rr_mode = 0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Sequencing controller for a differential memristive PUF cell pair. It accepts a challenge word over a valid/ready handshake and, for each challenge bit, drives opposite-polarity programming pulses into memristor cells A and B. After a settle period it compares the two cell conductances to form one response bit. It sits between the challenge interface and the two memristor cell instances, and owns all their `vin`/`vin_valid`/clear traffic.

## Interface
- `CHAL_BITS`, 8: challenge and response width; one bit per program/compare round.
- `VIN_WIDTH`, 16: cell drive width, signed Q.8 volts.
- `G_WIDTH`, 16: cell conductance width, signed.
- `VPROG`, 1280: programming magnitude (5.0 V in Q.8); must exceed the cell threshold of 4.0 V.
- `PULSE_CYCLES`, 4: cycles per programming pulse, ≥1.
- `SETTLE_CYCLES`, 2: idle cycles between pulse and sample, ≥0.
- `CLEAR_CYCLES`, 2: cycles `cell_clear` is held at challenge start, ≥1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high. One clock domain.
- `chal_valid`, in, 1: challenge offered.
- `chal_ready`, out, 1: high only in IDLE.
- `chal`, in, CHAL_BITS: challenge word; captured on the accept edge.
- `cell_clear`, out, 1: returns both cells to their initial conductance.
- `cell_vin_valid`, out, 1: drive strobe to both cells.
- `cell_vin_a`, `cell_vin_b`, out, VIN_WIDTH signed: drive voltages.
- `cell_g_a`, `cell_g_b`, in, G_WIDTH signed: cell conductances.
- `resp_valid`, out, 1: response available.
- `resp_ready`, in, 1: response consumed.
- `resp`, out, CHAL_BITS: response word.
- `tie_cnt`, out, 4: equal-conductance compares in the last challenge, saturating at 15.
- `busy`, out, 1: state is not IDLE.

## Operation
- States: IDLE → CLEAR → PROG → SETTLE → SAMPLE → [RESTORE] → (PROG for the next bit | DONE) → IDLE.
- **IDLE:** `chal_ready`=1. When `chal_valid`&&`chal_ready`:
  - latch `chal`
  - clear `resp` and `tie_cnt`
  - set bit index to 0
  - go to CLEAR.
- **CLEAR:** `cell_clear`=1 for CLEAR_CYCLES cycles, then go to PROG.
- **PROG:** `cell_vin_valid`=1 for PULSE_CYCLES cycles.
  - Challenge bit i=1: `cell_vin_a`=+VPROG, `cell_vin_b`=−VPROG.
  - Challenge bit i=0: polarities swapped.
- **SETTLE:** `cell_vin_valid`=0 and both drives=0 for SETTLE_CYCLES cycles. SETTLE_CYCLES=0 skips this state.
- **SAMPLE:** lasts one cycle.
  - `resp[i]` = (`cell_g_a` > `cell_g_b`), signed compare.
  - If the two are equal, `resp[i]`=0 and `tie_cnt` increments (saturating).
- After the last bit (i=CHAL_BITS−1), go to DONE. Otherwise increment i and go to PROG.
- **DONE:** `resp_valid`=1 and `resp` stays stable until `resp_ready`. Then go to IDLE.
- Bits are processed LSB first. A `chal_valid` arriving outside IDLE is ignored and the bench must hold it.
- Whenever `cell_vin_valid`=0, drive outputs are 0.

## Timing
- Reset values: `chal_ready`=0, `cell_clear`=0, `cell_vin_valid`=0, `cell_vin_a`/`cell_vin_b`=0, `resp_valid`=0, `resp`=0, `tie_cnt`=0, `busy`=0, state=IDLE.
- `chal_ready` rises on the first clock edge after `rst` deasserts.
- All outputs are registered.
- Accept edge = edge E. `cell_clear` is high from cycle E+1.
- Per-bit cost = PULSE_CYCLES + SETTLE_CYCLES + 1 cycles, plus PULSE_CYCLES with restore enabled.
- `resp_valid` rises at E+1+CLEAR_CYCLES+CHAL_BITS×(per-bit cost). With defaults this is E+59, or E+91 with restore.
- `cell_g_*` are sampled on the SAMPLE edge; the cells must present settled values by then.
- Response handshake: if `resp_ready` is already high when `resp_valid` rises, the transfer completes on that edge. `chal_ready` reasserts on the next cycle.
- Reset mid-challenge: all outputs return to their reset values immediately. The challenge and partial response are discarded. No `resp_valid` is produced.

## Configuration
- `PUF_SEQ_RESTORE_EN` defined: after each SAMPLE, a RESTORE state drives PULSE_CYCLES cycles of the inverse polarity of that bit's PROG pulse, returning the cells toward their pre-bit state.
- `PUF_SEQ_RESTORE_EN` undefined: no RESTORE state; SAMPLE goes directly to PROG or DONE.

## Structure
- Package `puf_seq_pkg`:
  - state enum
  - `TIE_CNT_W`=4
  - polarity helper constants
- Sub-module `puf_pulse_timer`: loadable down-counter with a `done` flag. It is reused for CLEAR, PROG, SETTLE and RESTORE durations.

## Test plan
- Reset then idle: `rst` pulse → all outputs at reset values; `chal_ready`=1 one edge after release; `busy`=0.
- Polarity: `chal`=8'h01, stub cells → during bit-0 PROG `cell_vin_a`=+1280, `cell_vin_b`=−1280; for bits 1–7 the signs are swapped; each pulse is exactly 4 cycles.
- Response: stub `cell_g_a`=200, `cell_g_b`=100 for even bits, reversed for odd bits → `resp`=8'h55, `tie_cnt`=0, `resp_valid` at E+59.
- Tie: stubs equal at 128 for every bit → `resp`=8'h00, `tie_cnt`=8.
- Backpressure and reset: hold `resp_ready`=0 for 10 cycles → `resp` stable and `chal_ready`=0 throughout. Separately, assert `rst` during bit 3 PROG → drives go to 0 at once, no `resp_valid`, next challenge runs normally.
- `PUF_SEQ_RESTORE_EN` defined: each PROG is followed after SAMPLE by 4 cycles of inverse polarity; `resp_valid` at E+91.
